sort4_ctrl: RTL and testbench
=============================

# sort4_ctrl

Sequencing controller that sorts a burst of N 4-bit values using one shared `four_bit_comp` magnitude comparator. It sits in front of the comparator datapath and owns it completely:
- accepts N values over a valid/ready load port;
- bubble-sorts them in place, one comparison per cycle;
- streams the sorted result out over a valid/ready drain port.

## Interface
- `N`, default 4: number of entries per burst; legal range 2..8.
- `DESCEND`, default 0: 0 sorts ascending (swap on `g`); 1 sorts descending (swap on `s`).
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: `in_data` is offered.
- `in_ready` output 1: block accepts load data.
- `in_data` input 4: value to load.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: consumer accepts `out_data`.
- `out_data` output 4: sorted value, index 0 first.
- `out_last` output 1: marks the final (N-th) output beat.
- `busy` output 1: high while in SORT.
- `swap_count` output 8: number of swaps performed in the current or most recent sort; saturates at 255.

## Operation
- Storage: `mem[0..N-1]`, 4 bits each.
- Counters: load/drain index `idx`, compare index `i` (0..N-2), pass counter `p` (0..N-2), and a `swapped` flag.
- States: LOAD, SORT, DRAIN.
- LOAD:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: `mem[idx] <= in_data`, `idx++`.
  - When the accept takes `idx` to N: go to SORT with `i`=0, `p`=0, `swapped`=0 and `swap_count`=0.
- SORT:
  - The comparator is driven with a=`mem[i]`, b=`mem[i+1]`.
  - If the swap condition holds (`g` for ascending, `s` for descending): exchange the two entries, set `swapped`, increment `swap_count`.
  - Equal values (`e`) never swap, so the sort is stable.
  - `i++` each cycle.
  - At `i`=N-2, the pass ends:
    - If `swapped`=0 or `p`=N-2: go to DRAIN with `idx`=0.
    - Otherwise: `p++`, `i`=0, clear `swapped`.
- DRAIN:
  - `out_valid` = 1, `out_data` = `mem[idx]`, `out_last` = (`idx`==N-1).
  - On `out_valid && out_ready`: `idx++`.
  - The last beat returns to LOAD with `idx`=0.
- `in_ready` is 0 in SORT and DRAIN. Load data offered then is ignored, not buffered.
- `swap_count` holds its value through DRAIN and LOAD until the next SORT entry.

## Timing
- Reset values:
  - State LOAD.
  - `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0, `out_data`=0, `swap_count`=0.
  - All `mem` entries 0; `idx`, `i`, `p` and `swapped` cleared.
- Reset asserted mid-LOAD, mid-SORT or mid-DRAIN aborts the burst: the next cycle shows the reset values and partial data is discarded.
- Load takes N accepting cycles minimum. `busy` rises the cycle after the N-th accept.
- Sort latency:
  - Minimum N-1 cycles: one pass, input already sorted.
  - Maximum (N-1)² cycles.
  - For N=4: 3 to 9 cycles.
- `out_valid` rises the cycle after the last compare. `busy` falls in that same cycle.
- Drain:
  - One beat per cycle while `out_ready`=1.
  - `out_data`/`out_valid` must hold stable while `out_ready`=0.
- After the last drain beat, `in_ready`=1 on the next cycle. There is no overlap of LOAD with DRAIN.
- All outputs are functions of registered state only. There is no combinational path from `in_valid`/`out_ready` to any output.

## Structure
- Package `sort4_pkg`:
  - state enum (LOAD, SORT, DRAIN);
  - localparam `W`=4 (comparator width);
  - localparam `SWAP_CNT_W`=8.
- One sub-module instance: `four_bit_comp` (ports `a`, `b`, `g`, `e`, `s`), used combinationally in SORT.
- The swap mux and the FSM live in `sort4_ctrl`. No other hierarchy.

## Test plan
- Reset, then load 0xA, 0x5, 0x8, 0x1 (N=4, ascending) → `busy` for 9 cycles, output 0x1, 0x5, 0x8, 0xA, `out_last` on 0xA, `swap_count`=5.
- Load 0x1, 0x2, 0x3, 0x4 → early exit after 3 SORT cycles, output unchanged, `swap_count`=0.
- Load 0x4, 0x4, 0x4, 0x4 → 3 SORT cycles, `swap_count`=0, output four 0x4 beats.
- Load 0xF, 0xE, 0xD, 0xC ascending → 9 SORT cycles, `swap_count`=6, output 0xC, 0xD, 0xE, 0xF. Same input with `DESCEND`=1 → `swap_count`=0, output 0xF, 0xE, 0xD, 0xC.
- Drain with `out_ready` toggled 1, 0, 0, 1, 1, 0, 1 → each value appears exactly once in order and holds stable while stalled. `in_valid` held high during SORT/DRAIN is not accepted.
- Assert `rst` for one cycle during SORT (2nd compare) → next cycle: LOAD, `in_ready`=1, `busy`=0, `swap_count`=0. A following load of 0x3, 0x0, 0x2, 0x1 sorts to 0x0, 0x1, 0x2, 0x3.

Source files
------------

// File: rtl/sort4_pkg.sv
// rtl/sort4_pkg.sv - shared types and widths for the sort4 controller
package sort4_pkg;

   typedef enum logic [1:0] {
      LOAD,
      SORT,
      DRAIN
   } state_t;

   localparam int W          = 4;
   localparam int SWAP_CNT_W = 8;

endpackage

// File: rtl/four_bit_comp.sv
// rtl/four_bit_comp.sv - combinational magnitude comparator
module four_bit_comp
   import sort4_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         g,
   output logic         e,
   output logic         s
);

   assign g = (a > b);
   assign e = (a == b);
   assign s = (a < b);

endmodule

// File: rtl/sort4_ctrl.sv
// rtl/sort4_ctrl.sv - load / in-place bubble sort / drain controller
// sharing a single four_bit_comp comparator
module sort4_ctrl
   import sort4_pkg::*;
#(
   parameter int N       = 4,
   parameter bit DESCEND = 1'b0
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [W-1:0]          out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic [SWAP_CNT_W-1:0] swap_count
);

   // One spare bit so every index counter can address the whole power-of-two store
   localparam int IW    = $clog2(N) + 1;
   localparam int DEPTH = 1 << IW;

   state_t                  state, state_n;
   logic [IW-1:0]           idx, idx_n;
   logic [IW-1:0]           i, i_n;
   logic [IW-1:0]           p, p_n;
   logic                    swapped, swapped_n;
   logic [SWAP_CNT_W-1:0]   swap_cnt, swap_cnt_n;
   logic [W-1:0]            mem   [DEPTH];
   logic [W-1:0]            mem_n [DEPTH];

   logic [IW-1:0]           i_next;
   logic                    cmp_g, cmp_e, cmp_s;
   logic                    do_swap;

   assign i_next = i + 1'b1;

   four_bit_comp u_comp (
      .a (mem[i]),
      .b (mem[i_next]),
      .g (cmp_g),
      .e (cmp_e),
      .s (cmp_s)
   );

   // Equal neighbours never exchange, which keeps the sort stable
   assign do_swap = (state == SORT) && !cmp_e && (DESCEND ? cmp_s : cmp_g);

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      i_n        = i;
      p_n        = p;
      swapped_n  = swapped;
      swap_cnt_n = swap_cnt;
      mem_n      = mem;

      case (state)
         LOAD: begin
            if (in_valid) begin
               mem_n[idx] = in_data;
               idx_n      = idx + 1'b1;
               if (idx == IW'(N - 1)) begin
                  state_n    = SORT;
                  idx_n      = '0;
                  i_n        = '0;
                  p_n        = '0;
                  swapped_n  = 1'b0;
                  swap_cnt_n = '0;
               end
            end
         end

         SORT: begin
            if (do_swap) begin
               mem_n[i]      = mem[i_next];
               mem_n[i_next] = mem[i];
               swapped_n     = 1'b1;
               if (swap_cnt != '1) begin
                  swap_cnt_n = swap_cnt + 1'b1;
               end
            end
            if (i == IW'(N - 2)) begin
               // A swap on the final compare still counts toward this pass
               if (!(swapped || do_swap) || (p == IW'(N - 2))) begin
                  state_n = DRAIN;
                  idx_n   = '0;
               end else begin
                  p_n       = p + 1'b1;
                  i_n       = '0;
                  swapped_n = 1'b0;
               end
            end else begin
               i_n = i_next;
            end
         end

         DRAIN: begin
            if (out_ready) begin
               if (idx == IW'(N - 1)) begin
                  state_n = LOAD;
                  idx_n   = '0;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end

         default: state_n = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= LOAD;
         idx      <= '0;
         i        <= '0;
         p        <= '0;
         swapped  <= 1'b0;
         swap_cnt <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            mem[k] <= '0;
         end
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         i        <= i_n;
         p        <= p_n;
         swapped  <= swapped_n;
         swap_cnt <= swap_cnt_n;
         mem      <= mem_n;
      end
   end

   assign in_ready   = (state == LOAD);
   assign busy       = (state == SORT);
   assign out_valid  = (state == DRAIN);
   assign out_data   = out_valid ? mem[idx] : '0;
   assign out_last   = out_valid && (idx == IW'(N - 1));
   assign swap_count = swap_cnt;

endmodule

// File: tb/tb_sort4_ctrl.sv
// tb/tb_sort4_ctrl.sv - bench for sort4_ctrl: ascending and descending instances
// against a burst-level bubble-sort model plus literal expectations
module tb_sort4_ctrl;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst_s       [2];
   logic       in_valid_s  [2];
   logic [3:0] in_data_s   [2];
   logic       out_ready_s [2];
   logic       in_ready_w  [2];
   logic       out_valid_w [2];
   logic [3:0] out_data_w  [2];
   logic       out_last_w  [2];
   logic       busy_w      [2];
   logic [7:0] swap_w      [2];

   always #5 clk = ~clk;

   sort4_ctrl #(.N(N), .DESCEND(1'b0)) dut_asc (
      .clk(clk), .rst(rst_s[0]),
      .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]), .in_data(in_data_s[0]),
      .out_valid(out_valid_w[0]), .out_ready(out_ready_s[0]), .out_data(out_data_w[0]),
      .out_last(out_last_w[0]), .busy(busy_w[0]), .swap_count(swap_w[0])
   );

   sort4_ctrl #(.N(N), .DESCEND(1'b1)) dut_desc (
      .clk(clk), .rst(rst_s[1]),
      .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]), .in_data(in_data_s[1]),
      .out_valid(out_valid_w[1]), .out_ready(out_ready_s[1]), .out_data(out_data_w[1]),
      .out_last(out_last_w[1]), .busy(busy_w[1]), .swap_count(swap_w[1])
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Burst-level model: phase 0 loading, 1 sorting, 2 draining
   int         m_phase [2] = '{0, 0};
   int         m_cnt   [2] = '{0, 0};
   int         m_left  [2] = '{0, 0};
   int         m_swaps [2] = '{0, 0};
   int         m_didx  [2] = '{0, 0};
   bit         desc    [2] = '{1'b0, 1'b1};
   logic [3:0] m_vals   [2][8];
   logic [3:0] m_sorted [2][8];

   logic [3:0] cap_data [$];
   logic       cap_last [$];
   int         busy_n   [2] = '{0, 0};

   task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", nm, k, act, exp, $time);
      end
   endtask

   function automatic void model_sort(input int k);
      logic [3:0] a [8];
      logic [3:0] t;
      int cyc;
      int sw;
      bit any;
      for (int j = 0; j < 8; j++) a[j] = m_vals[k][j];
      cyc = 0;
      sw  = 0;
      for (int ps = 0; ps < N - 1; ps++) begin
         any = 1'b0;
         for (int j = 0; j < N - 1; j++) begin
            cyc++;
            if (desc[k] ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
               any = 1'b1;
               sw++;
            end
         end
         if (!any) break;
      end
      for (int j = 0; j < 8; j++) m_sorted[k][j] = a[j];
      m_left[k]  = cyc;
      m_swaps[k] = (sw > 255) ? 255 : sw;
   endfunction

   initial forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst_s[k]) begin
            m_phase[k] = 0; m_cnt[k] = 0; m_swaps[k] = 0; m_didx[k] = 0;
         end else if (m_phase[k] == 0) begin
            if (in_valid_s[k]) begin
               m_vals[k][m_cnt[k]] = in_data_s[k];
               m_cnt[k]++;
               if (m_cnt[k] == N) begin
                  model_sort(k);
                  m_phase[k] = 1;
               end
            end
         end else if (m_phase[k] == 1) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
               m_phase[k] = 2;
               m_didx[k]  = 0;
            end
         end else if (out_ready_s[k]) begin
            m_didx[k]++;
            if (m_didx[k] == N) begin
               m_phase[k] = 0;
               m_cnt[k]   = 0;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         if (busy_w[k]) busy_n[k]++;
         if (out_valid_w[k] && out_ready_s[k]) begin
            cap_data.push_back(out_data_w[k]);
            cap_last.push_back(out_last_w[k]);
         end
         if (chk_en) begin
            check("in_ready", k, 32'(in_ready_w[k]), 32'(m_phase[k] == 0));
            check("busy", k, 32'(busy_w[k]), 32'(m_phase[k] == 1));
            check("out_valid", k, 32'(out_valid_w[k]), 32'(m_phase[k] == 2));
            check("out_last", k, 32'(out_last_w[k]), 32'(m_phase[k] == 2 && m_didx[k] == N - 1));
            if (m_phase[k] == 2)
               check("out_data", k, 32'(out_data_w[k]), 32'(m_sorted[k][m_didx[k]]));
            if (m_phase[k] != 1)
               check("swap_count", k, 32'(swap_w[k]), 32'(m_swaps[k]));
         end
      end
   end

   task automatic load4(input int k, input logic [3:0] v [4], input bit hold);
      for (int j = 0; j < 4; j++) begin
         in_valid_s[k] = 1'b1;
         in_data_s[k]  = v[j];
         @(posedge clk); #1;
      end
      in_valid_s[k] = hold;
      in_data_s[k]  = 4'h7;
   endtask

   task automatic burst(input int k, input logic [3:0] v [4], input bit hold, input bit stall);
      bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int t;
      cap_data.delete();
      cap_last.delete();
      busy_n[k] = 0;
      load4(k, v, hold);
      t = 0;
      while (!out_valid_w[k] && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) check("sort_timeout", k, 32'(t), 32'(0));
      t = 0;
      while (cap_data.size() < N && t < 100) begin
         out_ready_s[k] = stall ? pat[t % 7] : 1'b1;
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) check("drain_timeout", k, 32'(t), 32'(0));
      out_ready_s[k] = 1'b0;
      in_valid_s[k]  = 1'b0;
   endtask

   task automatic expect_out(input string nm, input int k, input logic [3:0] e [4],
                             input int busy_exp, input int swaps_exp);
      check({nm, "_beats"}, k, 32'(cap_data.size()), 32'(N));
      for (int j = 0; j < N && j < cap_data.size(); j++) begin
         check({nm, "_data"}, k, 32'(cap_data[j]), 32'(e[j]));
         check({nm, "_last"}, k, 32'(cap_last[j]), 32'(j == N - 1));
      end
      check({nm, "_busy_cycles"}, k, 32'(busy_n[k]), 32'(busy_exp));
      check({nm, "_swaps"}, k, 32'(swap_w[k]), 32'(swaps_exp));
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst_s[k] = 1'b1; in_valid_s[k] = 1'b0; in_data_s[k] = 4'h0; out_ready_s[k] = 1'b0;
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         check("rst_in_ready", k, 32'(in_ready_w[k]), 32'(1));
         check("rst_out_valid", k, 32'(out_valid_w[k]), 32'(0));
         check("rst_out_last", k, 32'(out_last_w[k]), 32'(0));
         check("rst_busy", k, 32'(busy_w[k]), 32'(0));
         check("rst_out_data", k, 32'(out_data_w[k]), 32'(0));
         check("rst_swap", k, 32'(swap_w[k]), 32'(0));
      end
      rst_s[0] = 1'b0;
      rst_s[1] = 1'b0;
      chk_en   = 1'b1;

      burst(0, '{4'hA, 4'h5, 4'h8, 4'h1}, 1'b0, 1'b0);
      expect_out("mixed", 0, '{4'h1, 4'h5, 4'h8, 4'hA}, 9, 5);

      burst(0, '{4'h1, 4'h2, 4'h3, 4'h4}, 1'b0, 1'b0);
      expect_out("sorted", 0, '{4'h1, 4'h2, 4'h3, 4'h4}, 3, 0);

      burst(0, '{4'h4, 4'h4, 4'h4, 4'h4}, 1'b0, 1'b0);
      expect_out("equal", 0, '{4'h4, 4'h4, 4'h4, 4'h4}, 3, 0);

      burst(0, '{4'hF, 4'hE, 4'hD, 4'hC}, 1'b0, 1'b0);
      expect_out("reverse_asc", 0, '{4'hC, 4'hD, 4'hE, 4'hF}, 9, 6);

      burst(1, '{4'hF, 4'hE, 4'hD, 4'hC}, 1'b0, 1'b0);
      expect_out("reverse_desc", 1, '{4'hF, 4'hE, 4'hD, 4'hC}, 3, 0);

      burst(0, '{4'hA, 4'h5, 4'h8, 4'h1}, 1'b1, 1'b1);
      expect_out("stall", 0, '{4'h1, 4'h5, 4'h8, 4'hA}, 9, 5);
      @(posedge clk); #1;
      check("post_drain_in_ready", 0, 32'(in_ready_w[0]), 32'(1));

      load4(0, '{4'hA, 4'h5, 4'h8, 4'h1}, 1'b0);
      @(posedge clk); #1;
      rst_s[0] = 1'b1;
      @(posedge clk); #1;
      rst_s[0] = 1'b0;
      check("abort_in_ready", 0, 32'(in_ready_w[0]), 32'(1));
      check("abort_busy", 0, 32'(busy_w[0]), 32'(0));
      check("abort_swap", 0, 32'(swap_w[0]), 32'(0));
      check("abort_out_valid", 0, 32'(out_valid_w[0]), 32'(0));

      burst(0, '{4'h3, 4'h0, 4'h2, 4'h1}, 1'b0, 1'b0);
      expect_out("after_abort", 0, '{4'h0, 4'h1, 4'h2, 4'h3}, 9, 4);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
